// File: rtl/sram_resp_pkg.sv
// rtl/sram_resp_pkg.sv - shared types and constants for the SRAM responder
package sram_resp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int          READ_LAT_MAX = 4;
  localparam logic [31:0] RD_OOR       = 32'h0;

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - delay line carrying {err, data} behind the array read stage
module sram_rd_pipe #(
  parameter int STAGES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [32:0] pipe_d,
  output logic [32:0] pipe_q
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;
      assign pipe_q = pipe_d;
    end else begin : g_delay
      logic [32:0] stage [STAGES];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
          stage[0] <= pipe_d;
          for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
      end

      assign pipe_q = stage[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - single-port SRAM responder with post-reset zero fill
module data_sram_resp
  import sram_resp_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h1c00_0000,
  parameter int          AW        = 16,
  parameter int          READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        sram_err,
  output logic        init_done,
  output logic [31:0] wr_cnt
);

  localparam int DEPTH       = 1 << AW;
  localparam int LAT_CLAMP   = (READ_LAT < 1) ? 1 :
                               (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
  localparam int PIPE_STAGES = LAT_CLAMP - 1;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_idx;
  logic [31:0]     mem [DEPTH];
  logic            in_range;
  logic [AW-1:0]   idx;
  logic            wr_ok;
  logic [32:0]     s0_q;
  logic [32:0]     pipe_q;
  logic            unused_addr_lsb;

  assign in_range        = (sram_addr[31:AW+2] == ADDR_BASE[31:AW+2]);
  assign idx             = sram_addr[AW+1:2];
  assign unused_addr_lsb = ^sram_addr[1:0];
  assign wr_ok           = (state == ST_READY) && sram_we && in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    init_done = 1'b0;
    case (state)
      ST_CLEAR: if (&clr_idx) state_nxt = ST_READY;
      ST_READY: init_done = 1'b1;
    endcase
  end

  // Clear owns the array port until READY; initiator writes are dropped meanwhile.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) mem[clr_idx] <= '0;
    else if (wr_ok)        mem[idx]     <= sram_wdata;
  end

  // Array read stage samples the pre-write word, giving read-before-write.
  always_ff @(posedge clk) begin
    if (reset)                  s0_q <= '0;
    else if (state != ST_READY) s0_q <= '0;
    else if (in_range)          s0_q <= {1'b0, mem[idx]};
    else                        s0_q <= {1'b1, RD_OOR};
  end

  always_ff @(posedge clk) begin
    if (reset)      wr_cnt <= '0;
    else if (wr_ok) wr_cnt <= wr_cnt + 32'd1;
  end

  sram_rd_pipe #(.STAGES(PIPE_STAGES)) u_rd_pipe (
    .clk    (clk),
    .reset  (reset),
    .pipe_d (s0_q),
    .pipe_q (pipe_q)
  );

  assign {sram_err, sram_rdata} = pipe_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - self-checking bench for data_sram_resp at read latency 1 and 3
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] rdata1, rdata3, cnt1, cnt3;
  logic        err1, err3, done1, done3;

  logic        cur_chk;
  logic [31:0] cur_data;
  logic        cur_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        chk;
    logic [31:0] data;
    logic        err;
  } sb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [31:0] exp_cnt;
  } vec_t;

  sb_t  q1[$];
  sb_t  q3[$];
  vec_t tbl [15];

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_BASE(32'h1c00_0000), .AW(4), .READ_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(rdata1), .sram_err(err1),
    .init_done(done1), .wr_cnt(cnt1)
  );

  data_sram_resp #(.ADDR_BASE(32'h1c00_0000), .AW(4), .READ_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(rdata3), .sram_err(err3),
    .init_done(done3), .wr_cnt(cnt3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected read results enter at the sampling edge and leave after READ_LAT edges.
  always @(posedge clk) begin : scoreboard
    sb_t e;
    if (reset) begin
      q1.delete();
      q3.delete();
    end else begin
      e.chk  = cur_chk;
      e.data = cur_data;
      e.err  = cur_err;
      q1.push_back(e);
      q3.push_back(e);
    end
    #1;
    if (q1.size() >= 1) begin
      e = q1.pop_front();
      if (e.chk) begin
        check("lat1_rdata", rdata1, e.data);
        check("lat1_err", {31'b0, err1}, {31'b0, e.err});
      end
    end
    if (q3.size() >= 3) begin
      e = q3.pop_front();
      if (e.chk) begin
        check("lat3_rdata", rdata3, e.data);
        check("lat3_err", {31'b0, err3}, {31'b0, e.err});
      end
    end
  end

  task automatic acc(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic c, input logic [31:0] ed, input logic ee);
    sram_we    = we;
    sram_addr  = addr;
    sram_wdata = wd;
    cur_chk    = c;
    cur_data   = ed;
    cur_err    = ee;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_phase(input string tag);
    for (int i = 0; i < 16; i++) begin
      check({tag, "_init_low"}, {31'b0, done1}, 32'd0);
      acc(1'b1, 32'h1c00_0000, 32'hffff_ffff, 1'b1, 32'h0, 1'b0);
    end
    check({tag, "_init_high1"}, {31'b0, done1}, 32'd1);
    check({tag, "_init_high3"}, {31'b0, done3}, 32'd1);
    check({tag, "_cnt_after_clear"}, cnt1, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'h1c00_0000, 32'h0,         32'h0,         1'b0, 32'd0};
    tbl[1]  = '{1'b1, 32'h1c00_0008, 32'h1234_5678, 32'h0,         1'b0, 32'd1};
    tbl[2]  = '{1'b0, 32'h1c00_000b, 32'h0,         32'h1234_5678, 1'b0, 32'd1};
    tbl[3]  = '{1'b1, 32'h1c00_0004, 32'h1111_1111, 32'h0,         1'b0, 32'd2};
    tbl[4]  = '{1'b1, 32'h1c00_0004, 32'haaaa_5555, 32'h1111_1111, 1'b0, 32'd3};
    tbl[5]  = '{1'b0, 32'h1c00_0004, 32'h0,         32'haaaa_5555, 1'b0, 32'd3};
    tbl[6]  = '{1'b0, 32'h1c00_0040, 32'h0,         32'h0,         1'b1, 32'd3};
    tbl[7]  = '{1'b1, 32'h1c00_0040, 32'hdead_beef, 32'h0,         1'b1, 32'd3};
    tbl[8]  = '{1'b0, 32'h1c00_0000, 32'h0,         32'h0,         1'b0, 32'd3};
    tbl[9]  = '{1'b1, 32'h1c00_0000, 32'h0000_000a, 32'h0,         1'b0, 32'd4};
    tbl[10] = '{1'b1, 32'h1c00_0004, 32'h0000_000b, 32'haaaa_5555, 1'b0, 32'd5};
    tbl[11] = '{1'b0, 32'h1c00_0000, 32'h0,         32'h0000_000a, 1'b0, 32'd5};
    tbl[12] = '{1'b0, 32'h1c00_0004, 32'h0,         32'h0000_000b, 1'b0, 32'd5};
    tbl[13] = '{1'b0, 32'h2000_0000, 32'h0,         32'h0,         1'b1, 32'd5};
    tbl[14] = '{1'b0, 32'h1c00_003c, 32'h0,         32'h0,         1'b0, 32'd5};

    reset      = 1'b1;
    sram_we    = 1'b0;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    cur_chk    = 1'b0;
    cur_data   = 32'h0;
    cur_err    = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rdata", rdata1, 32'h0);
    check("rst_err", {31'b0, err1}, 32'd0);
    check("rst_init_done", {31'b0, done1}, 32'd0);
    check("rst_wr_cnt", cnt1, 32'd0);
    check("rst_rdata3", rdata3, 32'h0);
    reset = 1'b0;

    clear_phase("boot");

    for (int i = 0; i < 15; i++) begin
      acc(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b1, tbl[i].exp_data, tbl[i].exp_err);
      check($sformatf("vec%0d_wr_cnt", i), cnt1, tbl[i].exp_cnt);
      check($sformatf("vec%0d_wr_cnt3", i), cnt3, tbl[i].exp_cnt);
    end
    repeat (3) acc(1'b0, 32'h1c00_0000, 32'h0, 1'b1, 32'h0000_000a, 1'b0);

    acc(1'b1, 32'h1c00_0000, 32'h5, 1'b1, 32'h0000_000a, 1'b0);
    check("pre_reset_cnt", cnt1, 32'd6);
    reset = 1'b1;
    acc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    repeat (8) acc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("midclear_init_low", {31'b0, done1}, 32'd0);
    reset = 1'b1;
    acc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    reset = 1'b0;

    clear_phase("reclear");
    acc(1'b0, 32'h1c00_0000, 32'h0, 1'b1, 32'h0, 1'b0);
    acc(1'b0, 32'h1c00_0004, 32'h0, 1'b1, 32'h0, 1'b0);
    repeat (3) acc(1'b0, 32'h1c00_0000, 32'h0, 1'b1, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
